fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `insmem`. It owns the program counter and drives the instruction-memory address. It captures the combinational instruction word into a small in-order fetch buffer and presents it to decode through a valid/ready handshake. It also handles control-flow redirects from execute by flushing the buffer and reloading the PC.

---
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, buffers fetched words in order and hands them to decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_ins,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_ins,
    output logic [31:0] dec_pc,
    output logic        misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_bufPc  [DEPTH];
    logic [31:0]   r_bufIns [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_misalign;

    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_fetchStall;
    logic [31:0]   w_targetPc;
    logic          w_targetMis;

`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned target is loaded as-is and parks fetch until the next aligned redirect.
    assign w_targetPc  = redirect_pc;
    assign w_targetMis = |redirect_pc[1:0];
`else
    assign w_targetPc  = redirect_pc & 32'hFFFF_FFFC;
    assign w_targetMis = 1'b0;
`endif

    assign w_fetchStall = r_misalign;
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop        = dec_valid & dec_ready;
    assign w_push       = ~w_fetchStall & (~w_full | w_pop);

    assign mem_addr  = r_pc;
    assign dec_valid = (r_count != '0);
    assign dec_ins   = r_bufIns[r_head];
    assign dec_pc    = r_bufPc[r_head];
    assign misalign  = r_misalign;

    // Reset beats redirect, which beats the normal push/pop traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_bufPc[i]  <= 32'h0;
                r_bufIns[i] <= 32'h0;
            end
        end else if (redirect) begin
            r_pc       <= w_targetPc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= w_targetMis;
        end else begin
            if (w_push) begin
                r_bufPc[r_tail]  <= r_pc;
                r_bufIns[r_tail] <= mem_ins;
                r_tail           <= r_tail + PW'(1);
                r_pc             <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_ins;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_ins;
    logic [31:0] dec_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_ins    (mem_ins),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_ins    (dec_ins),
        .dec_pc     (dec_pc),
        .misalign   (misalign)
    );

    // Instruction memory contents: two fixed words, everything else a scrambled function of address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: memWord = 32'h0000_10B7;
            32'h0000_0004: memWord = 32'h0000_8193;
            default:       memWord = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    assign mem_ins = memWord(mem_addr);

    // Reference model: a queue of fetched {pc, ins} pairs in program order.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mPc = 32'h0;
    logic        mMis = 1'b0;
    logic        modelLive = 1'b0;

    always @(posedge clk) begin
        bit doPop;
        bit doPush;
        if (reset === 1'b1) begin
            mq.delete();
            mPc       = RESET_PC;
            mMis      = 1'b0;
            modelLive = 1'b1;
        end else if (modelLive) begin
            if (redirect) begin
                mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                mPc  = redirect_pc;
                mMis = (redirect_pc[1:0] != 2'b00);
`else
                mPc  = {redirect_pc[31:2], 2'b00};
                mMis = 1'b0;
`endif
            end else begin
                doPop  = (mq.size() > 0) && dec_ready;
                doPush = !mMis && ((mq.size() < DEPTH) || doPop);
                if (doPop) void'(mq.pop_front());
                if (doPush) begin
                    mq.push_back('{pc: mPc, ins: memWord(mPc)});
                    mPc = mPc + 32'd4;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every cycle after the first reset, the DUT must agree with the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("model mem_addr", mem_addr, mPc);
            checkOutput("model dec_valid", {31'h0, dec_valid}, {31'h0, mq.size() != 0});
            checkOutput("model misalign", {31'h0, misalign}, {31'h0, mMis});
            if (mq.size() != 0) begin
                checkOutput("model dec_pc", dec_pc, mq[0].pc);
                checkOutput("model dec_ins", dec_ins, mq[0].ins);
            end
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic applyStimulus(input logic rst, input logic rdr, input logic [31:0] rpc, input logic rdy);
        reset       = rst;
        redirect    = rdr;
        redirect_pc = rpc;
        dec_ready   = rdy;
        @(negedge clk);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("reset dec_valid", {31'h0, dec_valid}, 32'h0);
        checkOutput("reset dec_ins", dec_ins, 32'h0);
        checkOutput("reset dec_pc", dec_pc, 32'h0);
        checkOutput("reset mem_addr", mem_addr, RESET_PC);
        checkOutput("reset misalign", {31'h0, misalign}, 32'h0);

        applyStimulus(0, 0, 0, 1);
        checkOutput("first dec_valid", {31'h0, dec_valid}, 32'h1);
        checkOutput("first dec_pc", dec_pc, 32'h0);
        checkOutput("first dec_ins", dec_ins, 32'h0000_10B7);
        checkOutput("first mem_addr", mem_addr, 32'h4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("second dec_pc", dec_pc, 32'h4);
        checkOutput("second dec_ins", dec_ins, 32'h0000_8193);
        applyStimulus(0, 0, 0, 1);
        checkOutput("third dec_pc", dec_pc, 32'h8);

        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("bp mem_addr frozen", mem_addr, 32'(4 * DEPTH));
        checkOutput("bp dec_pc head", dec_pc, 32'h0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("bp mem_addr still", mem_addr, 32'(4 * DEPTH));
        checkOutput("bp dec_ins held", dec_ins, 32'h0000_10B7);

        applyStimulus(0, 0, 0, 1);
        checkOutput("full pop dec_pc", dec_pc, 32'h4);
        checkOutput("full pop mem_addr", mem_addr, 32'(4 * DEPTH + 4));
        applyStimulus(0, 0, 0, 0);
        checkOutput("full hold mem_addr", mem_addr, 32'(4 * DEPTH + 4));
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("resume dec_pc", dec_pc, 32'hC);
        applyStimulus(0, 0, 0, 0);

        applyStimulus(0, 1, 32'h4, 1);
        checkOutput("redirect dec_valid", {31'h0, dec_valid}, 32'h0);
        checkOutput("redirect mem_addr", mem_addr, 32'h4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("redirect tgt valid", {31'h0, dec_valid}, 32'h1);
        checkOutput("redirect tgt pc", dec_pc, 32'h4);
        checkOutput("redirect tgt ins", dec_ins, 32'h0000_8193);

        applyStimulus(1, 1, 32'h40, 1);
        checkOutput("rst+rdr mem_addr", mem_addr, RESET_PC);
        checkOutput("rst+rdr dec_valid", {31'h0, dec_valid}, 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst+rdr dec_pc", dec_pc, RESET_PC);

        applyStimulus(0, 1, 32'hFFFF_FFF8, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap pc0", dec_pc, 32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap pc1", dec_pc, 32'hFFFF_FFFC);
        checkOutput("wrap mem_addr", mem_addr, 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap pc2", dec_pc, 32'h0);
        checkOutput("wrap ins2", dec_ins, 32'h0000_10B7);

`ifdef FETCH_MISALIGN_TRAP_EN
        applyStimulus(0, 1, 32'h6, 1);
        checkOutput("mis set", {31'h0, misalign}, 32'h1);
        checkOutput("mis mem_addr", mem_addr, 32'h6);
        applyStimulus(0, 0, 0, 1);
        checkOutput("mis no valid", {31'h0, dec_valid}, 32'h0);
        checkOutput("mis sticky", {31'h0, misalign}, 32'h1);
        applyStimulus(0, 1, 32'h0, 1);
        checkOutput("mis clear", {31'h0, misalign}, 32'h0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("mis resume pc", dec_pc, 32'h0);
        checkOutput("mis resume valid", {31'h0, dec_valid}, 32'h1);
`else
        applyStimulus(0, 1, 32'h6, 1);
        checkOutput("unaligned mem_addr", mem_addr, 32'h4);
        applyStimulus(0, 0, 0, 1);
        checkOutput("unaligned dec_pc", dec_pc, 32'h4);
        checkOutput("unaligned misalign", {31'h0, misalign}, 32'h0);
`endif

        for (int i = 0; i < 80; i++) begin
            applyStimulus(0, ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 63)),
                          logic'($urandom_range(0, 1)));
        end
        applyStimulus(0, 1, 32'h0, 1);
        applyStimulus(0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
